// File: rtl/clk_div_prog_pkg.sv
// Shared timebase definitions for the programmable clock divider.
package clk_div_prog_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // ceil(n/2); the 32-bit argument leaves headroom so n = 2^WIDTH-1 cannot overflow
  function automatic logic [31:0] half_ceil(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             div_busy;
  logic             div_err;
  logic [WIDTH-1:0] div_active;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] count;

  modport master (
    output en, div_val, div_load,
    input  div_busy, div_err, div_active, clk_out, tick, count
  );

  modport slave (
    input  en, div_val, div_load,
    output div_busy, div_err, div_active, clk_out, tick, count
  );
endinterface

// File: rtl/clk_div_period_ctr.sv
// Period counter: counts 0..n_i-1 while running, flags the last position as wrap.
module clk_div_period_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [WIDTH-1:0] n_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_nxt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_s;

  // next count: held at zero when stopped, wraps after n_i-1
  always_comb begin
    wrap_s = run_i && (count_q == (n_i - WIDTH'(1)));
    if (!run_i || wrap_s) begin
      count_d = {WIDTH{1'b0}};
    end else begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign count_nxt_o = count_d;
  assign wrap_o      = wrap_s;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor updates
// applied at period boundaries through a load/busy handshake.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 16
) (
  input logic             clk,
  input logic             rst_n,
  clk_div_prog_if.slave   bus
);

  localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV_W = WIDTH'(MIN_DIV);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] count_nxt_s;
  logic             wrap_s;
  logic             apply_s;
  logic             bad_val_s;

  clk_div_period_ctr #(
    .WIDTH(WIDTH)
  ) u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_i       (state_q == ST_RUN),
    .n_i         (active_q),
    .count_o     (count_s),
    .count_nxt_o (count_nxt_s),
    .wrap_o      (wrap_s)
  );

  // FSM next state, divisor handshake and duty decode
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    clk_out_d = 1'b0;

    // a pending divisor takes effect only where no period is in progress
    apply_s = busy_q && ((state_q == ST_IDLE) || wrap_s);
    if (apply_s) begin
      active_d = pend_q;
      busy_d   = 1'b0;
    end else begin
      active_d = active_q;
    end

    // a load on the boundary edge stays pending for the next boundary
    bad_val_s = (bus.div_val < MIN_DIV_W);
    if (bus.div_load) begin
      pend_d = bad_val_s ? MIN_DIV_W : bus.div_val;
      busy_d = 1'b1;
      err_d  = bad_val_s;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (wrap_s && !bus.en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) begin
      clk_out_d = (32'(count_nxt_s) < half_ceil(32'(active_d)));
    end else begin
      clk_out_d = 1'b0;
    end
  end

  // state and divisor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      active_q  <= DEF_DIV_W;
      pend_q    <= DEF_DIV_W;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign bus.div_busy   = busy_q;
  assign bus.div_err    = err_q;
  assign bus.div_active = active_q;
  assign bus.clk_out    = clk_out_q;
  assign bus.tick       = wrap_s;
  assign bus.count      = count_s;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog against a period-level reference model.
module tb_clk_div_prog;
  localparam int WIDTH       = 8;
  localparam int DEFAULT_DIV = 16;

  logic clk = 1'b0;
  logic rst_n;

  clk_div_prog_if #(.WIDTH(WIDTH)) bus ();

  clk_div_prog #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model: whether a period is running, position in it, divisors
  bit m_run;
  int m_pos;
  int m_n;
  int m_pend;
  bit m_pv;
  bit m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void model_reset();
    m_run  = 1'b0;
    m_pos  = 0;
    m_n    = DEFAULT_DIV;
    m_pend = DEFAULT_DIV;
    m_pv   = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_edge(input bit e, input bit ld, input int v);
    bit last;
    bit take;
    int n_next;
    last   = m_run && (m_pos == m_n - 1);
    take   = m_pv && (!m_run || last);
    n_next = take ? m_pend : m_n;
    m_err  = ld && (v < 2);
    if (ld) begin
      m_pend = (v < 2) ? 2 : v;
      m_pv   = 1'b1;
    end else if (take) begin
      m_pv = 1'b0;
    end
    if (!m_run) begin
      m_run = e;
      m_pos = 0;
    end else if (last) begin
      m_run = e;
      m_pos = 0;
    end else begin
      m_pos = m_pos + 1;
    end
    m_n = n_next;
  endfunction

  task automatic check_all();
    chk("count",      32'(bus.count),      32'(m_pos));
    chk("clk_out",    32'(bus.clk_out),    32'(m_run && (m_pos < (m_n + 1) / 2)));
    chk("tick",       32'(bus.tick),       32'(m_run && (m_pos == m_n - 1)));
    chk("div_busy",   32'(bus.div_busy),   32'(m_pv));
    chk("div_err",    32'(bus.div_err),    32'(m_err));
    chk("div_active", 32'(bus.div_active), 32'(m_n));
  endtask

  task automatic cyc(input bit e, input bit ld, input int v);
    bus.en       = e;
    bus.div_load = ld;
    bus.div_val  = WIDTH'(v);
    @(posedge clk);
    model_edge(e, ld, v);
    #1;
    check_all();
  endtask

  initial begin
    int v;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_active", 32'(bus.div_active), 32'(DEFAULT_DIV));
    rst_n = 1'b1;

    // default divisor of 16 from reset release
    cyc(1'b1, 1'b0, 0);
    chk("first_rise", 32'(bus.clk_out), 32'd1);
    repeat (40) cyc(1'b1, 1'b0, 0);

    // load 5 mid-period
    for (int i = 0; i < 40 && m_pos != 2 + $urandom_range(0, 3); i++) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 5);
    chk("busy_after_load5", 32'(bus.div_busy), 32'd1);
    repeat (30) cyc(1'b1, 1'b0, 0);
    chk("active5", 32'(bus.div_active), 32'd5);

    // 7 then 9 back-to-back within one period: only 9 survives
    for (int i = 0; i < 20 && m_pos != 0; i++) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 7);
    cyc(1'b1, 1'b1, 9);
    repeat (40) cyc(1'b1, 1'b0, 0);
    chk("active9", 32'(bus.div_active), 32'd9);

    // invalid divisor clamps to 2
    cyc(1'b1, 1'b1, 1);
    chk("err_pulse", 32'(bus.div_err), 32'd1);
    cyc(1'b1, 1'b0, 0);
    chk("err_clear", 32'(bus.div_err), 32'd0);
    repeat (30) cyc(1'b1, 1'b0, 0);
    chk("active2", 32'(bus.div_active), 32'd2);

    // drop en at count 3 with N=10: period completes, then idle
    cyc(1'b1, 1'b1, 10);
    for (int i = 0; i < 60 && !(m_n == 10 && m_pos == 3); i++) cyc(1'b1, 1'b0, 0);
    chk("reach_n10_pos3", 32'(bus.count), 32'd3);
    repeat (6) cyc(1'b0, 1'b0, 0);
    chk("last_tick_n10", 32'(bus.tick), 32'd1);
    cyc(1'b0, 1'b0, 0);
    chk("idle_clk_out", 32'(bus.clk_out), 32'd0);
    chk("idle_count", 32'(bus.count), 32'd0);
    repeat (3) cyc(1'b0, 1'b0, 0);

    // load while idle applies on the following edge
    cyc(1'b0, 1'b1, 6);
    chk("idle_busy", 32'(bus.div_busy), 32'd1);
    cyc(1'b0, 1'b0, 0);
    chk("idle_active6", 32'(bus.div_active), 32'd6);
    repeat (15) cyc(1'b1, 1'b0, 0);

    // async reset with N=6 and 12 pending
    for (int i = 0; i < 20 && m_pos != 1; i++) cyc(1'b1, 1'b0, 0);
    cyc(1'b1, 1'b1, 12);
    chk("pending12_busy", 32'(bus.div_busy), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_async_clk_out", 32'(bus.clk_out), 32'd0);
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 0);
    chk("post_rst_active", 32'(bus.div_active), 32'(DEFAULT_DIV));
    chk("post_rst_busy", 32'(bus.div_busy), 32'd0);

    // randomized run/load traffic
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 24));
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
